// File: rtl/id_ex_operand_stage_if.sv
// ID->EX operand-stage signal bundle: ID-side request fields, forwarding sources and EX-side register outputs.
// master = ID/forwarding side driving the stage; slave = the stage itself.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [4:0]      id_rd_i;
  logic            id_we_i;
  logic            id_ls_op_i;
  logic [1:0]      fwd_sel_a_i;
  logic [1:0]      fwd_sel_b_i;
  logic            ld_dependence_i;
  logic [XLEN-1:0] ex_result_i;
  logic [XLEN-1:0] mem_result_i;
  logic [XLEN-1:0] wb_result_i;
  logic            ex_stall_i;
  logic            flush_i;
  logic            id_stall_o;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_op_a_o;
  logic [XLEN-1:0] ex_op_b_o;
  logic [4:0]      ex_rd_o;
  logic            ex_we_o;
  logic            ex_ls_op_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rs1_data_i, id_rs2_data_i,
           id_rd_i, id_we_i, id_ls_op_i, fwd_sel_a_i, fwd_sel_b_i, ld_dependence_i,
           ex_result_i, mem_result_i, wb_result_i, ex_stall_i, flush_i,
    input  id_stall_o, ex_valid_o, ex_pc_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_we_o, ex_ls_op_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rs1_data_i, id_rs2_data_i,
           id_rd_i, id_we_i, id_ls_op_i, fwd_sel_a_i, fwd_sel_b_i, ld_dependence_i,
           ex_result_i, mem_result_i, wb_result_i, ex_stall_i, flush_i,
    output id_stall_o, ex_valid_o, ex_pc_o, ex_op_a_o, ex_op_b_o, ex_rd_o, ex_we_o, ex_ls_op_o
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID->EX register with forwarding muxes and load-use bubble control; 1-cycle latency, ex_stall_i holds all state.
// ID_EX_PERF_EN adds saturating bubble / forwarded-capture counters.
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  id_ex_operand_stage_if.slave bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_fwd_cnt_o
`endif
);

  typedef enum logic {S_RUN, S_BUBBLE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [4:0]      r_rd;
  logic            r_we;
  logic            r_ls_op;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_ld_hazard;
  logic            w_bubble;
  logic            w_capture;
  logic            w_stall;

  always_comb begin
    w_op_a = '0;
    case (bus.fwd_sel_a_i)
      2'b00:   w_op_a = bus.id_rs1_data_i;
      2'b01:   w_op_a = bus.ex_result_i;
      2'b10:   w_op_a = bus.mem_result_i;
      default: w_op_a = bus.wb_result_i;
    endcase
    if (bus.id_rs1_i == 5'd0) w_op_a = '0;
  end

  always_comb begin
    w_op_b = '0;
    case (bus.fwd_sel_b_i)
      2'b00:   w_op_b = bus.id_rs2_data_i;
      2'b01:   w_op_b = bus.ex_result_i;
      2'b10:   w_op_b = bus.mem_result_i;
      default: w_op_b = bus.wb_result_i;
    endcase
    if (bus.id_rs2_i == 5'd0) w_op_b = '0;
  end

  assign w_ld_hazard = bus.id_valid_i & r_valid & r_ls_op & r_we & bus.ld_dependence_i &
                       (r_rd != 5'd0) & ((r_rd == bus.id_rs1_i) | (r_rd == bus.id_rs2_i));

  // Edge priority: flush > downstream stall > bubble insertion > normal capture.
  always_comb begin
    w_state_nxt = r_state;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    w_stall     = bus.ex_stall_i;
    if ((r_state == S_RUN) && w_ld_hazard) w_stall = 1'b1;
    if (bus.flush_i) begin
      w_state_nxt = S_RUN;
    end else if (!bus.ex_stall_i) begin
      if ((r_state == S_RUN) && w_ld_hazard) begin
        w_bubble    = 1'b1;
        w_state_nxt = S_BUBBLE;
      end else begin
        w_capture   = 1'b1;
        w_state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_ls_op <= 1'b0;
    end else if (bus.flush_i || w_bubble) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_capture) begin
      r_valid <= bus.id_valid_i;
      r_pc    <= bus.id_pc_i;
      r_op_a  <= w_op_a;
      r_op_b  <= w_op_b;
      r_rd    <= bus.id_rd_i;
      r_we    <= bus.id_we_i & bus.id_valid_i;
      r_ls_op <= bus.id_ls_op_i;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_fwd_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_bubble && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_capture && bus.id_valid_i && ((bus.fwd_sel_a_i != 2'b00) || (bus.fwd_sel_b_i != 2'b00))
          && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_fwd_cnt_o   = r_fwd_cnt;
`endif

  assign bus.id_stall_o = w_stall;
  assign bus.ex_valid_o = r_valid;
  assign bus.ex_pc_o    = r_pc;
  assign bus.ex_op_a_o  = r_op_a;
  assign bus.ex_op_b_o  = r_op_b;
  assign bus.ex_rd_o    = r_rd;
  assign bus.ex_we_o    = r_we;
  assign bus.ex_ls_op_o = r_ls_op;

endmodule
